// File: rtl/seg7_pkg.sv
// Shared definitions for the 8-digit 7-segment scan driver: FSM encoding,
// blank pattern and the active-low hex glyph table.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned DIGIT_W    = 3;
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned GLYPH_W    = 7;

    // All anodes / cathodes off (both buses are active-low)
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    // {g,f,e,d,c,b,a}, active-low, indexed by nibble value
    localparam logic [GLYPH_W-1:0] HEX7_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage : seg7_pkg

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0]         nibble_i,
    output logic [GLYPH_W-1:0] seg_c_o
);

    // Table lookup of the glyph for the current nibble
    always_comb begin
        seg_c_o = HEX7_TAB[nibble_i];
    end

endmodule : seg7_hex_decode

// File: rtl/seg7_scan_drv.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Inputs are snapshotted once per frame so a digit never shows a mix of old
// and new data. Optional digit blinking is enabled with `define SEG_BLINK_EN.
module seg7_scan_drv
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV_W  = 17,
    parameter int unsigned BLINK_DIV_W = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           disp_num,
    input  logic [NUM_DIGITS-1:0] point_in,
    input  logic [NUM_DIGITS-1:0] le_in,
    output logic [SEG_W-1:0]      seg_an,
    output logic [SEG_W-1:0]      seg_cat,
    output logic                  frame_done
);

    state_t                  state_q, state_d;
    logic [SCAN_DIV_W-1:0]   presc_q;
    logic [DIGIT_W-1:0]      digit_q;
    logic [31:0]             num_sh_q;
    logic [NUM_DIGITS-1:0]   point_sh_q;
    logic [NUM_DIGITS-1:0]   le_sh_q;

    logic [SEG_W-1:0]        seg_an_q, seg_an_d;
    logic [SEG_W-1:0]        seg_cat_q, seg_cat_d;
    logic                    frame_done_q, frame_done_d;

    logic                    tick_c;
    logic [3:0]              nibble_c;
    logic [GLYPH_W-1:0]      glyph_c;
    logic                    blank_c;

    assign tick_c   = &presc_q;
    assign nibble_c = num_sh_q[{digit_q, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .nibble_i (nibble_c),
        .seg_c_o  (glyph_c)
    );

`ifdef SEG_BLINK_EN
    logic [BLINK_DIV_W-1:0] blink_q;

    // Free-running blink phase counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_q + BLINK_DIV_W'(1);
        end
    end

    assign blank_c = blink_q[BLINK_DIV_W-1] & le_sh_q[digit_q];
`else
    // Blink disabled: le shadow and blink width are intentionally unused
    logic unused_blink_c;
    assign unused_blink_c = ^{le_sh_q, 1'(BLINK_DIV_W)};
    assign blank_c        = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one load cycle, then eight slots of scanning
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: state_d = S_SCAN;
            S_SCAN: begin
                if (tick_c && (digit_q == DIGIT_W'(NUM_DIGITS - 1))) begin
                    state_d = S_LOAD;
                end
            end
        endcase
    end

    // Output decode: blank during load, otherwise drive the current digit
    always_comb begin
        seg_an_d     = SEG_BLANK;
        seg_cat_d    = SEG_BLANK;
        frame_done_d = 1'b0;
        if (state_q == S_LOAD) begin
            frame_done_d = 1'b1;
        end else begin
            seg_an_d  = ~(SEG_W'(1) << digit_q);
            seg_cat_d = {~point_sh_q[digit_q], glyph_c};
            if (blank_c) begin
                seg_an_d = SEG_BLANK;
            end
        end
    end

    // Datapath: snapshot, prescaler, digit counter and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q      <= '0;
            digit_q      <= '0;
            num_sh_q     <= '0;
            point_sh_q   <= '0;
            le_sh_q      <= '0;
            seg_an_q     <= SEG_BLANK;
            seg_cat_q    <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            if (state_q == S_LOAD) begin
                num_sh_q   <= disp_num;
                point_sh_q <= point_in;
                le_sh_q    <= le_in;
                presc_q    <= '0;
                digit_q    <= '0;
            end else begin
                presc_q <= presc_q + SCAN_DIV_W'(1);
                if (tick_c) begin
                    digit_q <= digit_q + DIGIT_W'(1);
                end
            end
            seg_an_q     <= seg_an_d;
            seg_cat_q    <= seg_cat_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_an     = seg_an_q;
    assign seg_cat    = seg_cat_q;
    assign frame_done = frame_done_q;

endmodule : seg7_scan_drv

// File: tb/tb_seg7_scan_drv.sv
// Self-checking bench for seg7_scan_drv (SCAN_DIV_W=2, BLINK_DIV_W=6).
// Honours `define SEG_BLINK_EN the same way the design does.
module tb_seg7_scan_drv;

    localparam int SLOT  = 4;               // 2^SCAN_DIV_W
    localparam int FRAME = 1 + 8 * SLOT;    // 33 cycles
    localparam int BLINK = 64;              // 2^BLINK_DIV_W

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] disp_num;
    logic [7:0]  point_in;
    logic [7:0]  le_in;
    logic [7:0]  seg_an;
    logic [7:0]  seg_cat;
    logic        frame_done;

    seg7_scan_drv #(
        .SCAN_DIV_W  (2),
        .BLINK_DIV_W (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .disp_num   (disp_num),
        .point_in   (point_in),
        .le_in      (le_in),
        .seg_an     (seg_an),
        .seg_cat    (seg_cat),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Glyphs {g..a}, active-low
    logic [6:0] hex_glyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: edges since reset release and frame snapshot
    int          t = 0;
    logic [31:0] s_num;
    logic [7:0]  s_pt;
    logic [7:0]  s_le;
    logic [7:0]  e_an;
    logic [7:0]  e_cat;
    logic        e_fd;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0d got=%0h want=%0h @%0t", tag, t, obs, exp, $time);
        end
    endtask

    // Predict outputs after this edge from frame position arithmetic
    task automatic model_edge();
        int pos;
        int slot;
        int nib;
        if (!rst) begin
            t     = 0;
            e_an  = 8'hFF;
            e_cat = 8'hFF;
            e_fd  = 1'b0;
        end else begin
            pos = t % FRAME;
            if (pos == 0) begin
                s_num = disp_num;
                s_pt  = point_in;
                s_le  = le_in;
                e_an  = 8'hFF;
                e_cat = 8'hFF;
                e_fd  = 1'b1;
            end else begin
                slot  = (pos - 1) / SLOT;
                nib   = int'((s_num >> (4 * slot)) & 32'hF);
                e_cat = {~s_pt[slot], hex_glyph[nib]};
                e_an  = ~(8'd1 << slot);
`ifdef SEG_BLINK_EN
                if (((t % BLINK) >= BLINK / 2) && s_le[slot]) e_an = 8'hFF;
`endif
                e_fd  = 1'b0;
            end
            t++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("seg_an", 32'(seg_an), 32'(e_an));
        check_eq("seg_cat", 32'(seg_cat), 32'(e_cat));
        check_eq("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the next edge falls on frame position p
    task automatic align(input int p);
        for (int i = 0; i < FRAME && (t % FRAME) != p; i++) tick();
    endtask

    initial begin
        // Reset with random inputs
        rst      = 1'b0;
        disp_num = $urandom;
        point_in = 8'($urandom);
        le_in    = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            disp_num = $urandom;
            point_in = 8'($urandom);
            le_in    = 8'($urandom);
            tick();
        end

        // Scan order
        disp_num = 32'h76543210;
        point_in = 8'h00;
        le_in    = 8'h00;
        rst      = 1'b1;
        run(2 * FRAME);

        // Tear-free: change during digit 3
        align(1 + 3 * SLOT);
        disp_num = 32'hFFFFFFFF;
        run(2 * FRAME);

        // Decimal points
        align(0);
        disp_num = 32'h0;
        point_in = 8'h81;
        run(2 * FRAME);

        // Blink on digit 1, covering both blink phases
        point_in = 8'h00;
        disp_num = 32'h89ABCDEF;
        le_in    = 8'h02;
        run(5 * FRAME);

        // Reset during digit 5
        align(1 + 5 * SLOT);
        rst = 1'b0;
        tick();
        rst      = 1'b1;
        disp_num = 32'h13579BDF;
        point_in = 8'h5A;
        le_in    = 8'hA5;
        run(2 * FRAME);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                disp_num = $urandom;
                point_in = 8'($urandom);
                le_in    = 8'($urandom);
            end
            rst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_seg7_scan_drv
